serial_slice_adder: RTL and testbench
=====================================

// Module: serial_slice_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder/subtractor. Adds one SLICE-bit chunk per clock,
//  LSB slice first, and registers the carry between slices.
//  Trades latency for a short carry chain. Sits between operand producers and
//  result consumers using valid/ready handshakes on both sides.
//  Generalises the fixed 4-bit ripple adder with width, slice size,
//  a subtract mode, overflow detection and flow control.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of SLICE
//  SLICE  4   bits added per clock; NSLICE = WIDTH/SLICE (>=1)
// PORTS
//  CLK        in   1      rising-edge clock
//  RST_N      in   1      asynchronous active-low reset
//  IN_VALID   in   1      operands A, B, C_IN, SUB valid
//  IN_READY   out  1      block can accept an operation
//  A          in   WIDTH  operand A (unsigned or two's complement)
//  B          in   WIDTH  operand B
//  C_IN       in   1      carry in (add mode only)
//  SUB        in   1      0: S=A+B+C_IN; 1: S=A+~B+1 (C_IN ignored)
//  OUT_VALID  out  1      result valid
//  OUT_READY  in   1      consumer accepts result
//  S          out  WIDTH  sum/difference
//  C_OUT      out  1      carry out of MSB (in SUB mode, 1 = no borrow)
//  OVF        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - FSM has states IDLE, RUN and DONE. IN_READY = (state==IDLE).
//    OUT_VALID = (state==DONE).
//  - Reset (async assert, sync release): state=IDLE, slice counter=0, carry=0.
//    S, C_OUT and OVF are 0 and OUT_VALID is 0. IN_READY reads 1.
//  - IDLE: on an edge with IN_VALID&IN_READY:
//    - latch A, B (or ~B if SUB) and SUB;
//    - carry = SUB ? 1 : C_IN;
//    - counter = 0; state goes to RUN.
//  - RUN: on each edge:
//    - add slice[counter] of A and B' plus carry;
//    - write the SLICE-bit result into the working sum;
//    - update carry and increment counter.
//    - On the edge processing slice NSLICE-1, load S, C_OUT and OVF, then go to DONE.
//  - Latency: OUT_VALID rises exactly NSLICE cycles after the accept edge.
//  - DONE: S, C_OUT and OVF are held stable for as long as OUT_READY is low.
//    On an edge with OUT_VALID&OUT_READY the block goes to IDLE.
//    IN_READY is high in the following cycle.
//  - The block has no overlap: at most one operation is in flight.
//    Minimum period is NSLICE+2 cycles per operation.
//  - IN_VALID while not in IDLE is ignored. Inputs are sampled only on the accept edge,
//    so A and B may change freely afterwards.
//  - Output registers change only on the RUN->DONE edge and on reset. They keep
//    the last result while in IDLE and RUN.
//  - Arithmetic is modulo 2^WIDTH. OVF uses the carry into bit WIDTH-1,
//    taken from inside the last slice.
//  - With SLICE==WIDTH (NSLICE=1): RUN lasts one cycle and latency is 1.
//  - Reset mid-RUN or mid-DONE discards the operation immediately. No partial
//    result appears on S.
//  - Elaboration error if WIDTH%SLICE != 0 or SLICE < 1.
// TESTING (WIDTH=16, SLICE=4)
//  1. 0x1234+0x4321, C_IN=1, SUB=0 -> S=0x5556, C_OUT=0, OVF=0.
//     OUT_VALID rises 4 cycles after accept.
//  2. 0xFFFF+0x0001, C_IN=0 -> S=0x0000, C_OUT=1, OVF=0
//     (carry crosses all 4 slices).
//  3. 0x7FFF+0x0001 -> S=0x8000, C_OUT=0, OVF=1.
//     Then 0x8000+0x8000 -> S=0x0000, C_OUT=1, OVF=1.
//  4. SUB=1: 0x0005-0x0007 -> S=0xFFFE, C_OUT=0, OVF=0.
//     0x8000-0x0001 -> S=0x7FFF, C_OUT=1, OVF=1. C_IN=1 has no effect.
//  5. Hold OUT_READY=0 for 5 cycles in DONE:
//     - OUT_VALID, S, C_OUT and OVF stay stable;
//     - IN_READY=0, and a new IN_VALID is ignored;
//     - after release, IN_READY=1 on the next cycle.
//  6. Assert RST_N=0 after 2 RUN cycles:
//     - OUT_VALID=0, S=0 and IN_READY=1 asynchronously;
//     - the next operation 0x0101+0x0202 gives S=0x0303.
//     Repeat the run with SLICE=16 and check latency is 1.

Source files
------------

// File: rtl/serial_slice_adder.sv
// serial_slice_adder
//   Multi-cycle WIDTH-bit adder/subtractor. It adds one SLICE-bit chunk per
//   clock, starting with the least significant slice, and registers the
//   carry between slices. This keeps the carry chain short at the cost of
//   NSLICE cycles of latency. Only one operation is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a, b, c_in and sub are valid
//   in_ready   block can accept an operation (high only while IDLE)
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   c_in       carry in; used in add mode only
//   sub        0: s = a + b + c_in, 1: s = a + ~b + 1
//   out_valid  result valid (high only while DONE)
//   out_ready  consumer accepts the result
//   s          sum or difference, modulo 2^WIDTH
//   c_out      carry out of the MSB (in subtract mode, 1 means no borrow)
//   ovf        signed overflow: carry into the MSB xor carry out of the MSB
module serial_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  generate
    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
      $error("serial_slice_adder: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;      // already inverted when subtracting
  logic [WIDTH-1:0] sum_reg;    // working sum, filled one slice per cycle
  logic [WIDTH-1:0] sum_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_out_reg;
  logic             ovf_reg;

  logic             accept;
  logic             last_slice;
  logic             in_run;

  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [SLICE-1:0] a_cur;
  logic [SLICE-1:0] b_cur;
  logic [SLICE:0]   slice_add;
  logic             carry_into_msb;

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign accept     = in_valid & in_ready;
  assign in_run     = (state_reg == RUN);
  assign last_slice = (cnt_reg == LAST_CNT);

  // Slice views of the latched operands, and the working-sum update: only
  // the slice selected by the counter takes the fresh adder result.
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
      assign sum_next[gi*SLICE +: SLICE] =
        (in_run && (cnt_reg == CW'(gi))) ? slice_add[SLICE-1:0]
                                         : sum_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_cur     = a_sl[cnt_reg];
  assign b_cur     = b_sl[cnt_reg];
  assign slice_add = {1'b0, a_cur} + {1'b0, b_cur} + {{SLICE{1'b0}}, carry_reg};

  // A sum bit is a ^ b ^ carry_in, so the carry into the top bit of the
  // slice is recovered from that bit's operands and result.
  assign carry_into_msb = a_cur[SLICE-1] ^ b_cur[SLICE-1] ^ slice_add[SLICE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : c_in;
      cnt_reg   <= '0;
    end else if (in_run) begin
      sum_reg   <= sum_next;
      carry_reg <= slice_add[SLICE];
      cnt_reg   <= cnt_reg + CW'(1);
      // Output registers only move here, so consumers never see a partial sum.
      if (last_slice) begin
        s_reg     <= sum_next;
        c_out_reg <= slice_add[SLICE];
        ovf_reg   <= carry_into_msb ^ slice_add[SLICE];
      end
    end
  end

  assign s     = s_reg;
  assign c_out = c_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_slice_adder.sv
module tb_serial_slice_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic        c_in, sub;
  logic        in_valid0, in_valid1, out_ready0, out_ready1;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [15:0] s0, s1;
  logic        c_out0, c_out1, ovf0, ovf1;

  logic        m_in_ready, m_out_valid, m_c_out, m_ovf;
  logic [15:0] m_s;
  int          sel;

  int checks;
  int errors;

  vec_t vecs[10];
  vec_t sb[$];

  serial_slice_adder #(.WIDTH(16), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid0),
    .out_ready(out_ready0), .s(s0), .c_out(c_out0), .ovf(ovf0)
  );

  serial_slice_adder #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid1),
    .out_ready(out_ready1), .s(s1), .c_out(c_out1), .ovf(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    if (sel == 1) begin
      m_in_ready = in_ready1; m_out_valid = out_valid1;
      m_s = s1; m_c_out = c_out1; m_ovf = ovf1;
    end else begin
      m_in_ready = in_ready0; m_out_valid = out_valid0;
      m_s = s0; m_c_out = c_out0; m_ovf = ovf0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h at %0t", name, sel, act, exp, $time);
    end
  endtask

  task automatic set_in_valid(input logic v);
    if (sel == 1) in_valid1 = v; else in_valid0 = v;
  endtask

  task automatic set_out_ready(input logic v);
    if (sel == 1) out_ready1 = v; else out_ready0 = v;
  endtask

  // Accept an operation, track latency, compare against the scoreboard,
  // optionally hold out_ready low, then retire the result.
  task automatic run_op(input int d, input vec_t v, input int exp_lat, input int hold);
    int   n;
    int   lat;
    vec_t e;
    sel = d;
    n = 0;
    while (!m_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("in_ready_idle", {31'd0, m_in_ready}, 32'd1);
    a = v.a; b = v.b; c_in = v.cin; sub = v.sub;
    set_in_valid(1'b1);
    sb.push_back(v);
    @(posedge clk);
    #1;
    set_in_valid(1'b0);
    a = 16'($urandom); b = 16'($urandom); c_in = ~v.cin; sub = ~v.sub;
    lat = 0;
    while (!m_out_valid && lat < 20) begin
      chk("in_ready_busy", {31'd0, m_in_ready}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("out_valid", {31'd0, m_out_valid}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("s", {16'd0, m_s}, {16'd0, e.s});
      chk("c_out", {31'd0, m_c_out}, {31'd0, e.c});
      chk("ovf", {31'd0, m_ovf}, {31'd0, e.ovf});
      $display("dut%0d %04h %s %04h cin=%0b -> s=%04h c=%0b ovf=%0b lat=%0d",
               d, v.a, v.sub ? "-" : "+", v.b, v.cin, m_s, m_c_out, m_ovf, lat);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        a = 16'($urandom); b = 16'($urandom);
        set_in_valid(1'b1);
        @(posedge clk);
        #1;
        chk("hold_valid", {31'd0, m_out_valid}, 32'd1);
        chk("hold_in_ready", {31'd0, m_in_ready}, 32'd0);
        chk("hold_s", {16'd0, m_s}, {16'd0, e.s});
        chk("hold_c_out", {31'd0, m_c_out}, {31'd0, e.c});
        chk("hold_ovf", {31'd0, m_ovf}, {31'd0, e.ovf});
      end
      set_in_valid(1'b0);
      @(negedge clk);
      set_out_ready(1'b1);
      @(posedge clk);
      #1;
      set_out_ready(1'b0);
      chk("in_ready_after", {31'd0, m_in_ready}, 32'd1);
      chk("out_valid_after", {31'd0, m_out_valid}, 32'd0);
      chk("s_kept_idle", {16'd0, m_s}, {16'd0, e.s});
    end else begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, m_in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, m_out_valid}, 32'd0);
    chk({tag, "_s"}, {16'd0, m_s}, 32'd0);
    chk({tag, "_c_out"}, {31'd0, m_c_out}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, m_ovf}, 32'd0);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    sel = 0;
    //           a         b         cin   sub   s         c     ovf
    vecs[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0};
    vecs[7] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    vecs[9] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b0; out_ready1 = 1'b0;
    #12;
    sel = 0; check_reset_outputs("reset");
    sel = 1; check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        run_op(d, vecs[i], (d == 0) ? 4 : 1, 0);
      end
    end

    // Back-pressure: result held for 5 cycles while new requests are offered.
    run_op(0, vecs[0], 4, 5);

    // Reset two cycles into RUN: outputs clear at once, without a clock edge.
    sel = 0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0;
    set_in_valid(1'b1);
    @(posedge clk);
    #1;
    set_in_valid(1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_run");
    @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0};
    run_op(0, v, 4, 0);

    // Single-slice instance: reset while DONE, then a fresh operation.
    sel = 1;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b1; sub = 1'b0;
    set_in_valid(1'b1);
    @(posedge clk);
    #1;
    set_in_valid(1'b0);
    @(posedge clk);
    #1;
    chk("dut16_done", {31'd0, m_out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, v, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
